// File: rtl/router_pkg.sv
// router_pkg: shared constants and types for the store-and-forward router.
//   - state_e    : top-level FSM states
//   - HDR_BYTES  : fixed header length (SA, DA, LEN[4], CRC[4])
//   - ERR_*      : bit positions inside the error status vector
//   - OFS_*      : byte offsets of header fields within a packet
package router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2,
        ST_SEND  = 2'd3
    } state_e;

    localparam int HDR_BYTES = 10;

    localparam int ERR_LEN  = 0;
    localparam int ERR_CRC  = 1;
    localparam int ERR_SIZE = 2;
    localparam int ERR_BUSY = 3;

    localparam int OFS_SA  = 0;
    localparam int OFS_DA  = 1;
    localparam int OFS_LEN = 2;
    localparam int OFS_CRC = 6;
    localparam int OFS_PAY = 10;

endpackage

// File: rtl/router_buf.sv
// router_buf: single-port DEPTH x 8 packet buffer.
//   clk_i   : clock
//   we_i    : write enable (write wdata_i at addr_i)
//   addr_i  : shared read/write address
//   wdata_i : write byte
//   rdata_o : registered read data, valid one edge after addr_i is presented
module router_buf #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/router_dut.sv
// router_dut: byte-serial store-and-forward packet router.
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset
//   dut_inp    : ingress byte, qualified by inp_valid (one contiguous burst per packet)
//   dut_outp   : egress byte, zero whenever outp_valid is low
//   outp_valid : egress byte valid
//   busy       : packet being checked or forwarded; ingress bytes are dropped
//   error      : status of last packet [0] len, [1] crc, [2] short/overflow, [3] dropped input
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for the first byte of a packet
// RECV     | storing bytes, capturing LEN/CRC, summing payload
// CHECK    | one cycle: evaluate errors, prefetch buffer[0]
// SEND     | replay buffer[0..LEN-1], then one cycle to drop outp_valid
module router_dut
    import router_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dut_inp,
    input  logic       inp_valid,
    output logic [7:0] dut_outp,
    output logic       outp_valid,
    output logic       busy,
    output logic [3:0] error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_e        state_q, state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   len_q, len_d;
    logic [31:0]   crc_q, crc_d;
    logic [31:0]   sum_q, sum_d;
    logic [7:0]    dout_q, dout_d;
    logic          dvalid_q, dvalid_d;
    logic          busy_q, busy_d;
    logic [3:0]    err_q, err_d;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic [CW-1:0] tx_nxt;
    logic          size_bad, len_bad, crc_bad;

    router_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk_i   (clk),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (dut_inp),
        .rdata_o (mem_rdata)
    );

    assign tx_nxt   = tx_cnt_q + 1'b1;
    assign size_bad = (rx_cnt_q < CW'(HDR_BYTES)) || ovf_q;
    assign len_bad  = {{(32-CW){1'b0}}, rx_cnt_q} != len_q;
    assign crc_bad  = crc_q != sum_q;

    always_comb begin
        state_d  = state_q;
        rx_cnt_d = rx_cnt_q;
        tx_cnt_d = tx_cnt_q;
        ovf_d    = ovf_q;
        len_d    = len_q;
        crc_d    = crc_q;
        sum_d    = sum_q;
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        busy_d   = busy_q;
        err_d    = err_q;
        mem_we   = 1'b0;
        mem_addr = rx_cnt_q[AW-1:0];

        case (state_q)
            ST_IDLE: begin
                if (inp_valid) begin
                    mem_we   = 1'b1;
                    mem_addr = '0;
                    rx_cnt_d = CW'(1);
                    ovf_d    = 1'b0;
                    len_d    = '0;
                    crc_d    = '0;
                    sum_d    = '0;
                    err_d    = '0;
                    state_d  = ST_RECV;
                end
            end
            ST_RECV: begin
                if (inp_valid) begin
                    if (rx_cnt_q == CW'(DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        rx_cnt_d = rx_cnt_q + 1'b1;
                        // Header fields are captured on the fly so CHECK needs no buffer reads.
                        if (rx_cnt_q >= CW'(OFS_PAY)) begin
                            sum_d = sum_q + {24'b0, dut_inp};
                        end else if (rx_cnt_q >= CW'(OFS_CRC)) begin
                            crc_d = {crc_q[23:0], dut_inp};
                        end else if (rx_cnt_q >= CW'(OFS_LEN)) begin
                            len_d = {len_q[23:0], dut_inp};
                        end
                    end
                end else begin
                    busy_d  = 1'b1;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Prefetch byte 0 so it lands on dut_outp on the first SEND edge.
                mem_addr = '0;
                tx_cnt_d = '0;
                err_d[ERR_SIZE] = size_bad;
                err_d[ERR_LEN]  = len_bad;
                err_d[ERR_CRC]  = crc_bad;
                if (size_bad || len_bad || crc_bad) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_cnt_q == len_q[CW-1:0]) begin
                    dout_d   = '0;
                    dvalid_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    dout_d   = mem_rdata;
                    dvalid_d = 1'b1;
                    tx_cnt_d = tx_nxt;
                    mem_addr = tx_nxt[AW-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (busy_q && inp_valid) begin
            err_d[ERR_BUSY] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
            ovf_q    <= 1'b0;
            len_q    <= '0;
            crc_q    <= '0;
            sum_q    <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
            ovf_q    <= ovf_d;
            len_q    <= len_d;
            crc_q    <= crc_d;
            sum_q    <= sum_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign dut_outp   = dout_q;
    assign outp_valid = dvalid_q;
    assign busy       = busy_q;
    assign error      = err_q;

endmodule

// File: tb/tb_router_dut.sv
module tb_router_dut;

    logic       clk;
    logic       reset;
    logic [7:0] dut_inp;
    logic       inp_valid;
    logic [7:0] dut_outp;
    logic       outp_valid;
    logic       busy;
    logic [3:0] error;

    int vectors;
    int miscompares;

    logic [7:0] pkt[$];
    logic [7:0] sb[$];

    router_dut #(.DEPTH(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .dut_inp    (dut_inp),
        .inp_valid  (inp_valid),
        .dut_outp   (dut_outp),
        .outp_valid (outp_valid),
        .busy       (busy),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packet = SA, DA, LEN(be32), CRC(be32), payload p0, p0+pstep, ...
    task automatic build(input logic [7:0] sa, input logic [7:0] da, input int npay,
                         input logic [7:0] p0, input logic [7:0] pstep,
                         input int len_adj, input logic [31:0] crc_xor);
        logic [7:0]  pay[$];
        logic [31:0] sum;
        logic [31:0] len;
        logic [31:0] crc;
        logic [7:0]  b;
        pkt.delete();
        sum = 0;
        b   = p0;
        for (int i = 0; i < npay; i++) begin
            pay.push_back(b);
            sum = sum + {24'b0, b};
            b   = b + pstep;
        end
        len = 32'(10 + npay + len_adj);
        crc = sum ^ crc_xor;
        pkt.push_back(sa);
        pkt.push_back(da);
        for (int k = 3; k >= 0; k--) pkt.push_back(len[k*8 +: 8]);
        for (int k = 3; k >= 0; k--) pkt.push_back(crc[k*8 +: 8]);
        foreach (pay[i]) pkt.push_back(pay[i]);
    endtask

    task automatic send_pkt(input bit fwd);
        foreach (pkt[i]) begin
            if (fwd) sb.push_back(pkt[i]);
            dut_inp   = pkt[i];
            inp_valid = 1'b1;
            tick();
        end
        dut_inp   = 8'h00;
        inp_valid = 1'b0;
    endtask

    // Expect n forwarded bytes; optionally inject inp_valid during output cycles.
    task automatic expect_fwd(input string tag, input int n, input int inj_at, input int inj_n,
                              input logic [3:0] err_exp);
        logic [7:0] e;
        tick();
        chk({tag, "_busy_rise"}, busy, 1'b1);
        chk({tag, "_ov_check"}, outp_valid, 1'b0);
        tick();
        chk({tag, "_ov_lat"}, outp_valid, 1'b0);
        chk({tag, "_sb_level"}, sb.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i >= inj_at && i < inj_at + inj_n) begin
                inp_valid = 1'b1;
                dut_inp   = 8'hEE;
            end else begin
                inp_valid = 1'b0;
                dut_inp   = 8'h00;
            end
            tick();
            e = (sb.size() > 0) ? sb.pop_front() : 8'h00;
            chk({tag, "_ov"}, outp_valid, 1'b1);
            chk({tag, "_data"}, dut_outp, e);
        end
        inp_valid = 1'b0;
        dut_inp   = 8'h00;
        tick();
        chk({tag, "_ov_end"}, outp_valid, 1'b0);
        chk({tag, "_outp_end"}, dut_outp, 8'h00);
        chk({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_err"}, error, err_exp);
    endtask

    // Expect a rejected packet: busy for one cycle, masked error value, no output.
    task automatic expect_drop(input string tag, input logic [3:0] mask, input logic [3:0] exp);
        tick();
        chk({tag, "_busy_rise"}, busy, 1'b1);
        tick();
        chk({tag, "_busy_fall"}, busy, 1'b0);
        chk({tag, "_err"}, error & mask, exp);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_no_out"}, outp_valid, 1'b0);
            tick();
        end
    endtask

    initial begin
        logic [7:0] e;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        inp_valid   = 1'b0;
        dut_inp     = 8'h00;
        tick();
        tick();
        chk("rst_outp", dut_outp, 8'h00);
        chk("rst_ov", outp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", error, 4'b0000);
        reset = 1'b0;
        tick();

        // Good 12-byte packet, payload 10,20.
        build(8'h01, 8'h02, 2, 8'h10, 8'h10, 0, 32'h0);
        send_pkt(1'b1);
        expect_fwd("good", 12, -1, 0, 4'b0000);

        // Bad checksum 0x31.
        build(8'h01, 8'h02, 2, 8'h10, 8'h10, 0, 32'h1);
        send_pkt(1'b0);
        expect_drop("badcrc", 4'b1111, 4'b0010);

        // LEN=13 with 12 bytes on the wire.
        build(8'h01, 8'h02, 2, 8'h10, 8'h10, 1, 32'h0);
        send_pkt(1'b0);
        expect_drop("badlen", 4'b1111, 4'b0001);

        // Short 5-byte packet; length bit may also be set.
        pkt.delete();
        pkt.push_back(8'h01);
        pkt.push_back(8'h02);
        pkt.push_back(8'h00);
        pkt.push_back(8'h00);
        pkt.push_back(8'h00);
        send_pkt(1'b0);
        expect_drop("short", 4'b1110, 4'b0100);

        // Zero-length payload: LEN=10, CRC=0.
        build(8'h0A, 8'h0B, 0, 8'h00, 8'h00, 0, 32'h0);
        send_pkt(1'b1);
        expect_fwd("empty", 10, -1, 0, 4'b0000);

        // Three bytes offered during SEND are dropped.
        build(8'h01, 8'h02, 2, 8'h10, 8'h10, 0, 32'h0);
        send_pkt(1'b1);
        expect_fwd("busyin", 12, 3, 3, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busyin_idle_ov", outp_valid, 1'b0);
            chk("busyin_idle_busy", busy, 1'b0);
        end

        // Reset after 4 output bytes.
        build(8'h05, 8'h06, 6, 8'h41, 8'h03, 0, 32'h0);
        send_pkt(1'b1);
        tick();
        chk("rstmid_busy", busy, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            e = (sb.size() > 0) ? sb.pop_front() : 8'h00;
            chk("rstmid_ov", outp_valid, 1'b1);
            chk("rstmid_data", dut_outp, e);
        end
        reset = 1'b1;
        tick();
        chk("rstmid_ov0", outp_valid, 1'b0);
        chk("rstmid_outp0", dut_outp, 8'h00);
        chk("rstmid_busy0", busy, 1'b0);
        chk("rstmid_err0", error, 4'b0000);
        reset = 1'b0;
        sb.delete();
        tick();
        build(8'h01, 8'h02, 2, 8'h10, 8'h10, 0, 32'h0);
        send_pkt(1'b1);
        expect_fwd("after_rst", 12, -1, 0, 4'b0000);

        // Back-to-back packets, one idle cycle apart.
        build(8'h11, 8'h22, 3, 8'hFF, 8'h81, 0, 32'h0);
        send_pkt(1'b1);
        expect_fwd("b2b_a", 13, -1, 0, 4'b0000);
        build(8'h33, 8'h44, 5, 8'h07, 8'h13, 0, 32'h0);
        send_pkt(1'b1);
        expect_fwd("b2b_b", 15, -1, 0, 4'b0000);

        // Maximum-length good packet fills the buffer exactly.
        build(8'hA5, 8'h5A, 1014, 8'h00, 8'h07, 0, 32'h0);
        send_pkt(1'b1);
        expect_fwd("maxlen", 1024, -1, 0, 4'b0000);

        // One packet past the buffer size raises the size error.
        build(8'hA5, 8'h5A, 1020, 8'h01, 8'h01, 0, 32'h0);
        send_pkt(1'b0);
        expect_drop("ovf", 4'b0100, 4'b0100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
